// File: rtl/cam_i2c_write_sequencer.sv
// Camera register-write burst sequencer.
// Takes one command (camera select + burst length), walks the command map
// byte index and frames every 3-byte group (reg addr, data MSB, data LSB) as
// one I2C write transaction: START, device address, 3 bytes, STOP.
// A NACK anywhere in a group aborts it with a STOP and resends the whole
// group, up to MAX_RETRY extra attempts, before the burst is failed.
module cam_i2c_write_sequencer #(
    parameter logic [6:0]  CAM0_ADDR = 7'h5D,
    parameter logic [6:0]  CAM1_ADDR = 7'h48,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       sysClk,
    input  logic       rst,
    // command channel
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_cam_id,
    input  logic [4:0] cmd_byte_total,
    // command map lookup (combinational on the map side)
    output logic [4:0] map_byte_counter,
    input  logic [7:0] map_byte,
    // I2C byte engine
    output logic       i2c_start,
    output logic       i2c_stop,
    output logic [7:0] i2c_byte,
    output logic       i2c_byte_valid,
    input  logic       i2c_byte_ready,
    input  logic       i2c_ack_valid,
    input  logic       i2c_nack,
    input  logic       i2c_idle,
    // status
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEVA,
        S_DATA,
        S_WACK,
        S_STOP,
        S_WIDLE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t     r_state;
    logic       r_cam_id;
    logic [4:0] r_total;
    logic [4:0] r_base;
    logic [1:0] r_offset;
    logic [3:0] r_retry;
    logic       r_retry_flag;
    logic       r_after_dev;

    logic       r_cmd_ready;
    logic       r_busy;
    logic       r_start;
    logic       r_stop;
    logic       r_valid;
    logic       r_done;
    logic       r_error;

    logic       w_accept;
    logic       w_xfer;
    logic       w_total_ok;
    logic [4:0] w_base_next;
    logic [7:0] w_dev_byte;

    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_xfer      = r_valid & i2c_byte_ready;
    // Legal bursts are whole groups of three, 1..10 groups.
    assign w_total_ok  = (cmd_byte_total != 5'd0) &&
                         (cmd_byte_total <= 5'd30) &&
                         ((cmd_byte_total % 5'd3) == 5'd0);
    // Base never exceeds 27, so base + 3 fits in 5 bits.
    assign w_base_next = r_base + 5'd3;
    assign w_dev_byte  = {(r_cam_id ? CAM1_ADDR : CAM0_ADDR), 1'b0};

    assign map_byte_counter = r_base + {3'b000, r_offset};

    // The map lookup is zero-latency, so DATA forwards map_byte directly;
    // the counter only moves on state transitions, which keeps it stable
    // for as long as the byte is offered.
    assign i2c_byte = (r_state == S_DATA) ? map_byte :
                      (r_state == S_DEVA) ? w_dev_byte : 8'h00;

    assign cmd_ready      = r_cmd_ready;
    assign busy           = r_busy;
    assign i2c_start      = r_start;
    assign i2c_stop       = r_stop;
    assign i2c_byte_valid = r_valid;
    assign done           = r_done;
    assign error          = r_error;

    // Sequencer FSM: outputs are registered and set on entry to their state.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cam_id     <= 1'b0;
            r_total      <= 5'd0;
            r_base       <= 5'd0;
            r_offset     <= 2'd0;
            r_retry      <= 4'd0;
            r_retry_flag <= 1'b0;
            r_after_dev  <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_stop       <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cam_id     <= cmd_cam_id;
                        r_total      <= cmd_byte_total;
                        r_base       <= 5'd0;
                        r_offset     <= 2'd0;
                        r_retry      <= 4'd0;
                        r_retry_flag <= 1'b0;
                        r_cmd_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        if (w_total_ok) begin
                            r_state <= S_START;
                            r_start <= 1'b1;
                        end else begin
                            // Reject without touching the bus.
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_DEVA;
                    r_valid <= 1'b1;
                end
                S_DEVA: begin
                    if (w_xfer) begin
                        r_valid     <= 1'b0;
                        r_after_dev <= 1'b1;
                        r_state     <= S_WACK;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_valid     <= 1'b0;
                        r_after_dev <= 1'b0;
                        r_state     <= S_WACK;
                    end
                end
                S_WACK: begin
                    if (i2c_ack_valid) begin
                        if (i2c_nack) begin
                            r_retry_flag <= 1'b1;
                            r_state      <= S_STOP;
                            r_stop       <= 1'b1;
                        end else if (r_after_dev) begin
                            r_offset <= 2'd0;
                            r_state  <= S_DATA;
                            r_valid  <= 1'b1;
                        end else if (r_offset < 2'd2) begin
                            r_offset <= r_offset + 2'd1;
                            r_state  <= S_DATA;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= S_STOP;
                            r_stop  <= 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    r_state <= S_WIDLE;
                end
                S_WIDLE: begin
                    if (i2c_idle) begin
                        if (!r_retry_flag) begin
                            if (w_base_next < r_total) begin
                                r_base   <= w_base_next;
                                r_offset <= 2'd0;
                                r_retry  <= 4'd0;
                                r_state  <= S_START;
                                r_start  <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (r_retry < RETRY_LIMIT) begin
                            // Resend the same group from its first byte.
                            r_retry      <= r_retry + 4'd1;
                            r_retry_flag <= 1'b0;
                            r_offset     <= 2'd0;
                            r_state      <= S_START;
                            r_start      <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_valid     <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_i2c_write_sequencer.sv
// Bench for cam_i2c_write_sequencer: a behavioural I2C byte engine plus a
// scoreboard of expected transmitted bytes, pushed when a command is issued
// and popped as the engine accepts each byte.
module tb_cam_i2c_write_sequencer;

    logic       sysClk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_cam_id;
    logic [4:0] cmd_byte_total;
    logic [4:0] map_byte_counter;
    logic [7:0] map_byte;
    logic       i2c_start;
    logic       i2c_stop;
    logic [7:0] i2c_byte;
    logic       i2c_byte_valid;
    logic       i2c_byte_ready;
    logic       i2c_ack_valid;
    logic       i2c_nack;
    logic       i2c_idle;
    logic       busy;
    logic       done;
    logic       error;

    always #5 sysClk = ~sysClk;

    cam_i2c_write_sequencer dut (
        .sysClk           (sysClk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_cam_id       (cmd_cam_id),
        .cmd_byte_total   (cmd_byte_total),
        .map_byte_counter (map_byte_counter),
        .map_byte         (map_byte),
        .i2c_start        (i2c_start),
        .i2c_stop         (i2c_stop),
        .i2c_byte         (i2c_byte),
        .i2c_byte_valid   (i2c_byte_valid),
        .i2c_byte_ready   (i2c_byte_ready),
        .i2c_ack_valid    (i2c_ack_valid),
        .i2c_nack         (i2c_nack),
        .i2c_idle         (i2c_idle),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    // Command map contents: a distinct byte per index.
    function automatic logic [7:0] map_val(input logic [4:0] idx);
        return 8'hC3 ^ {idx, 3'b101};
    endfunction

    assign map_byte = map_val(map_byte_counter);

    logic [7:0] sb[$];
    int vec;
    int miss;

    // engine / monitor state
    int   n_start, n_stop, n_done, n_errp, n_ack_ok;
    int   pos, rel, wcnt, stall;
    int   nack_start_num, nack_pos;
    logic nack_dev_always;
    logic xfer, nack_now, prev_hold;
    logic [7:0] prev_byte;

    // One clock: sample DUT at negedge, respond as the engine just after posedge.
    task automatic step();
        logic [7:0] exp_b;
        @(negedge sysClk);
        xfer = 1'b0;
        nack_now = 1'b0;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (i2c_start && i2c_stop) begin
                vec++; miss++;
                $display("FAIL start_stop_overlap: both high at %0t", $time);
            end
            if (i2c_start) begin n_start++; pos = 0; end
            if (i2c_stop) begin n_stop++; rel = 2; end
            if (done) n_done++;
            if (error) n_errp++;
            if (prev_hold) begin
                vec++;
                if (i2c_byte_valid !== 1'b1 || i2c_byte !== prev_byte) begin
                    miss++;
                    $display("FAIL byte_stable: valid=%b byte=%h, need valid=1 byte=%h",
                             i2c_byte_valid, i2c_byte, prev_byte);
                end
            end
            xfer = i2c_byte_valid && i2c_byte_ready;
            prev_hold = i2c_byte_valid && !i2c_byte_ready;
            prev_byte = i2c_byte;
            if (xfer) begin
                vec++;
                if (sb.size() == 0) begin
                    miss++;
                    $display("FAIL byte_unexpected: got %h, scoreboard empty", i2c_byte);
                end else begin
                    exp_b = sb.pop_front();
                    if (i2c_byte !== exp_b) begin
                        miss++;
                        $display("FAIL byte_value: got %h, expected %h", i2c_byte, exp_b);
                    end
                end
                nack_now = (nack_dev_always && pos == 0) ||
                           (nack_start_num == n_start && nack_pos == pos);
                pos++;
            end
        end
        @(posedge sysClk);
        #1;
        if (rst) begin
            i2c_ack_valid  = 1'b0;
            i2c_nack       = 1'b0;
            i2c_idle       = 1'b1;
            i2c_byte_ready = (stall == 0);
            rel = 0;
            wcnt = 0;
        end else begin
            i2c_ack_valid = xfer;
            i2c_nack      = xfer && nack_now;
            if (xfer && !nack_now) n_ack_ok++;
            if (i2c_byte_valid) begin
                if (wcnt < stall) begin i2c_byte_ready = 1'b0; wcnt++; end
                else i2c_byte_ready = 1'b1;
            end else begin
                i2c_byte_ready = (stall == 0);
                wcnt = 0;
            end
            if (i2c_start) i2c_idle = 1'b0;
            else if (rel > 0) begin
                rel--;
                if (rel == 0) i2c_idle = 1'b1;
            end
        end
    endtask

    task automatic clear_stats(input int stl);
        n_start = 0; n_stop = 0; n_done = 0; n_errp = 0; n_ack_ok = 0;
        stall = stl;
        nack_start_num = -1; nack_pos = -1; nack_dev_always = 1'b0;
    endtask

    task automatic push_group(input logic cam, input int base);
        sb.push_back(cam ? 8'h90 : 8'hBA);
        for (int k = 0; k < 3; k++) sb.push_back(map_val(5'(base + k)));
    endtask

    // Offer a command until accepted; report start/error in the next cycle.
    task automatic send_cmd(input logic cam, input logic [4:0] total,
                            output logic st, output logic er);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1; cmd_cam_id = cam; cmd_byte_total = total;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = cmd_ready;
            step();
        end
        // Scramble the command inputs: the DUT must have latched them.
        cmd_valid = 1'b0; cmd_cam_id = ~cam; cmd_byte_total = 5'd7;
        st = i2c_start; er = error;
        vec++;
        if (!acc) begin
            miss++;
            $display("FAIL cmd_accept: not accepted within 20 cycles");
        end
    endtask

    task automatic wait_end(input int budget);
        int  base_cnt;
        logic got;
        base_cnt = n_done + n_errp;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (n_done + n_errp > base_cnt) got = 1'b1;
        end
        vec++;
        if (!got) begin
            miss++;
            $display("FAIL burst_timeout: no done/error within %0d cycles", budget);
        end
        step(); step();
    endtask

    task automatic check_end(input string nm, input int e_start, input int e_stop,
                             input int e_done, input int e_err);
        vec++;
        if (n_start != e_start || n_stop != e_stop || n_done != e_done || n_errp != e_err) begin
            miss++;
            $display("FAIL %s_counts: start/stop/done/error = %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                     nm, n_start, n_stop, n_done, n_errp, e_start, e_stop, e_done, e_err);
        end
        vec++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miss++;
            $display("FAIL %s_idle: busy=%b cmd_ready=%b, expected 0/1", nm, busy, cmd_ready);
        end
        vec++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL %s_leftover: %0d expected bytes never sent, expected 0", nm, sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            i2c_start !== 1'b0 || i2c_stop !== 1'b0 || i2c_byte_valid !== 1'b0 ||
            i2c_byte !== 8'h00 || map_byte_counter !== 5'd0) begin
            miss++;
            $display("FAIL %s: rdy=%b busy=%b done=%b err=%b st=%b sp=%b vld=%b byte=%h idx=%0d, expected 1,0,0,0,0,0,0,00,0",
                     nm, cmd_ready, busy, done, error, i2c_start, i2c_stop,
                     i2c_byte_valid, i2c_byte, map_byte_counter);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_outputs("reset_state");
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_cam0_burst();
        logic st, er;
        clear_stats(0);
        for (int g = 0; g < 9; g += 3) push_group(1'b0, g);
        send_cmd(1'b0, 5'd9, st, er);
        vec++;
        if (st !== 1'b1 || er !== 1'b0) begin
            miss++;
            $display("FAIL cam0_latency: start=%b error=%b after accept, expected 1/0", st, er);
        end
        wait_end(500);
        check_end("cam0", 3, 3, 1, 0);
    endtask

    task automatic test_cam1_stall();
        logic st, er;
        clear_stats(5);
        push_group(1'b1, 0);
        send_cmd(1'b1, 5'd3, st, er);
        wait_end(500);
        check_end("cam1_stall", 1, 1, 1, 0);
        stall = 0;
        step();
    endtask

    task automatic test_nack_retry();
        logic st, er;
        clear_stats(0);
        nack_start_num = 2; nack_pos = 3;
        push_group(1'b0, 0);
        push_group(1'b0, 3);
        push_group(1'b0, 3);
        send_cmd(1'b0, 5'd6, st, er);
        wait_end(500);
        check_end("nack_retry", 3, 3, 1, 0);
    endtask

    task automatic test_nack_exhaust();
        logic st, er;
        clear_stats(0);
        nack_dev_always = 1'b1;
        for (int a = 0; a < 3; a++) sb.push_back(8'hBA);
        send_cmd(1'b0, 5'd3, st, er);
        wait_end(500);
        check_end("nack_exhaust", 3, 3, 0, 1);
    endtask

    task automatic test_reject();
        logic st, er;
        logic [4:0] bad[2];
        bad[0] = 5'd4; bad[1] = 5'd0;
        clear_stats(0);
        for (int b = 0; b < 2; b++) begin
            send_cmd(1'b0, bad[b], st, er);
            vec++;
            if (er !== 1'b1 || st !== 1'b0) begin
                miss++;
                $display("FAIL reject_%0d: error=%b start=%b after accept, expected 1/0",
                         bad[b], er, st);
            end
            step(); step(); step();
        end
        check_end("reject", 0, 0, 0, 2);
    endtask

    task automatic test_reset_mid();
        logic st, er;
        int   stops_before;
        clear_stats(0);
        for (int g = 0; g < 9; g += 3) push_group(1'b0, g);
        send_cmd(1'b0, 5'd9, st, er);
        for (int i = 0; i < 100 && n_ack_ok < 2; i++) step();
        vec++;
        if (n_ack_ok < 2) begin
            miss++;
            $display("FAIL reset_mid_reach: %0d acks seen, expected 2", n_ack_ok);
        end
        step();
        stops_before = n_stop;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_async");
        step();
        step();
        rst = 1'b0;
        step(); step();
        vec++;
        if (n_stop != stops_before) begin
            miss++;
            $display("FAIL reset_mid_nostop: %0d stops after reset, expected 0",
                     n_stop - stops_before);
        end
        sb.delete();
        clear_stats(0);
        push_group(1'b1, 0);
        push_group(1'b1, 3);
        send_cmd(1'b1, 5'd6, st, er);
        wait_end(500);
        check_end("after_reset", 2, 2, 1, 0);
    endtask

    initial begin
        vec = 0; miss = 0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_cam_id = 1'b0; cmd_byte_total = 5'd0;
        i2c_byte_ready = 1'b1; i2c_ack_valid = 1'b0; i2c_nack = 1'b0; i2c_idle = 1'b1;
        xfer = 1'b0; nack_now = 1'b0; prev_hold = 1'b0; prev_byte = 8'h00;
        pos = 0; rel = 0; wcnt = 0;
        clear_stats(0);
        test_reset();
        test_cam0_burst();
        test_cam1_stall();
        test_nack_retry();
        test_nack_exhaust();
        test_reject();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
